// File: rtl/am2909_seq_ctrl.sv
// -----------------------------------------------------------------------------
// am2909_seq_ctrl
//
// Next-address controller for a cascade of Am2909 microprogram sequencer
// slices. It decodes a 4-bit microinstruction together with the condition
// input and drives the slice controls (S, FE_n, PUP, RE_n, ZERO_n, C) and
// the D-bus source enables (PL_n, MAP_n, VECT_n) in the same cycle. It holds
// the registered loop counter and a shadow copy of the slice stack pointer.
//
// Parameters:
//   CW          loop counter width in bits
//   STACK_DEPTH slice stack depth; SP width is clog2(STACK_DEPTH+1)
//
// Ports:
//   CP        in   common clock, rising edge
//   RST       in   synchronous reset, active-high
//   I[3:0]    in   microinstruction opcode
//   CC_n      in   condition test, active-low
//   CCEN_n    in   condition enable, active-low (1 forces pass)
//   HOLD      in   wait state: re-issue the current address, freeze state
//   D[CW-1:0] in   counter load value
//   S[1:0]    out  slice mux select: 00 uPC, 01 AR, 10 stack top, 11 D
//   FE_n      out  stack file enable, active-low
//   PUP       out  1 = push, 0 = pop
//   RE_n      out  AR load enable, active-low
//   ZERO_n    out  force address 0, active-low
//   C         out  incrementer carry-in
//   PL_n, MAP_n, VECT_n  out  D-source enables, one-hot active-low
//   CNT_ZERO  out  loop counter == 0
//   FULL      out  SP == STACK_DEPTH
//   OVF, UNF  out  sticky stack overflow / underflow
//
// Optional feature macro: AM2909_SEQ_CTRL_STACK_CHECK_EN
//   Defined:   a push while FULL sets OVF; a pop at SP==0 is suppressed
//              (FE_n=1) and sets UNF. Flags clear only on RST.
//   Undefined: OVF=UNF=0; a pop at SP==0 still drives FE_n=0, SP floors at 0.
// -----------------------------------------------------------------------------
module am2909_seq_ctrl #(
  parameter int CW          = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic          CP,
  input  logic          RST,
  input  logic [3:0]    I,
  input  logic          CC_n,
  input  logic          CCEN_n,
  input  logic          HOLD,
  input  logic [CW-1:0] D,
  output logic [1:0]    S,
  output logic          FE_n,
  output logic          PUP,
  output logic          RE_n,
  output logic          ZERO_n,
  output logic          C,
  output logic          PL_n,
  output logic          MAP_n,
  output logic          VECT_n,
  output logic          CNT_ZERO,
  output logic          FULL,
  output logic          OVF,
  output logic          UNF
);

  localparam int             SPW    = $clog2(STACK_DEPTH + 1);
  localparam logic [SPW-1:0] SP_MAX = SPW'(STACK_DEPTH);

  // Opcode map
  localparam logic [3:0] OP_JZ   = 4'd0;
  localparam logic [3:0] OP_CJS  = 4'd1;
  localparam logic [3:0] OP_JMAP = 4'd2;
  localparam logic [3:0] OP_CJP  = 4'd3;
  localparam logic [3:0] OP_PUSH = 4'd4;
  localparam logic [3:0] OP_JSRP = 4'd5;
  localparam logic [3:0] OP_CJV  = 4'd6;
  localparam logic [3:0] OP_JRP  = 4'd7;
  localparam logic [3:0] OP_RFCT = 4'd8;
  localparam logic [3:0] OP_RPCT = 4'd9;
  localparam logic [3:0] OP_CRTN = 4'd10;
  localparam logic [3:0] OP_CJPP = 4'd11;
  localparam logic [3:0] OP_LDCT = 4'd12;
  localparam logic [3:0] OP_LOOP = 4'd13;
  localparam logic [3:0] OP_CONT = 4'd14;
  localparam logic [3:0] OP_TWB  = 4'd15;

  // Mux select encodings
  localparam logic [1:0] SEL_UPC = 2'b00;
  localparam logic [1:0] SEL_AR  = 2'b01;
  localparam logic [1:0] SEL_STK = 2'b10;
  localparam logic [1:0] SEL_D   = 2'b11;

  // State
  logic [CW-1:0]  r_cnt;
  logic [SPW-1:0] r_sp;

  // Decoded controls (before HOLD/RST overrides)
  logic           w_pass;
  logic           w_cnt_nz;
  logic           w_full;
  logic           w_empty;
  logic [1:0]     w_s;
  logic           w_push;
  logic           w_pop;
  logic           w_pop_eff;
  logic           w_re_n;
  logic           w_zero_n;
  logic           w_pl_n;
  logic           w_map_n;
  logic           w_vect_n;
  logic           w_load;
  logic           w_dec;
  logic           w_clr_sp;

  assign w_pass   = CCEN_n | ~CC_n;
  assign w_cnt_nz = (r_cnt != '0);
  assign w_full   = (r_sp == SP_MAX);
  assign w_empty  = (r_sp == '0);

  // ---------------------------------------------------------------------------
  // Opcode decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_s      = SEL_UPC;
    w_push   = 1'b0;
    w_pop    = 1'b0;
    w_re_n   = 1'b1;
    w_zero_n = 1'b1;
    w_pl_n   = 1'b0;
    w_map_n  = 1'b1;
    w_vect_n = 1'b1;
    w_load   = 1'b0;
    w_dec    = 1'b0;
    w_clr_sp = 1'b0;

    unique case (I)
      OP_JZ: begin
        w_zero_n = 1'b0;
        w_clr_sp = 1'b1;
      end
      OP_CJS: begin
        if (w_pass) begin
          w_s    = SEL_D;
          w_push = 1'b1;
        end
      end
      OP_JMAP: begin
        w_s     = SEL_D;
        w_map_n = 1'b0;
        w_pl_n  = 1'b1;
      end
      OP_CJP: begin
        if (w_pass) w_s = SEL_D;
      end
      OP_PUSH: begin
        w_push = 1'b1;
        w_load = w_pass;
      end
      OP_JSRP: begin
        w_push = 1'b1;
        w_s    = w_pass ? SEL_D : SEL_AR;
      end
      OP_CJV: begin
        if (w_pass) begin
          w_s      = SEL_D;
          w_vect_n = 1'b0;
          w_pl_n   = 1'b1;
        end
      end
      OP_JRP: begin
        w_s = w_pass ? SEL_D : SEL_AR;
      end
      OP_RFCT: begin
        // Loop back to the stacked address until the count runs out, then
        // fall through and discard the loop entry.
        if (w_cnt_nz) begin
          w_s   = SEL_STK;
          w_dec = 1'b1;
        end else begin
          w_pop = 1'b1;
        end
      end
      OP_RPCT: begin
        if (w_cnt_nz) begin
          w_s   = SEL_D;
          w_dec = 1'b1;
        end
      end
      OP_CRTN: begin
        if (w_pass) begin
          w_s   = SEL_STK;
          w_pop = 1'b1;
        end
      end
      OP_CJPP: begin
        if (w_pass) begin
          w_s   = SEL_D;
          w_pop = 1'b1;
        end
      end
      OP_LDCT: begin
        w_load = 1'b1;
        w_re_n = 1'b0;
      end
      OP_LOOP: begin
        if (w_pass) w_pop = 1'b1;
        else        w_s   = SEL_STK;
      end
      OP_CONT: begin
        w_s = SEL_UPC;
      end
      OP_TWB: begin
        // Three-way branch: exit on pass, loop on stack while counting,
        // branch to D and drop the loop entry when the count is exhausted.
        if (w_pass) begin
          w_pop = 1'b1;
        end else if (w_cnt_nz) begin
          w_s   = SEL_STK;
          w_dec = 1'b1;
        end else begin
          w_s   = SEL_D;
          w_pop = 1'b1;
        end
      end
      default: begin
        w_s = SEL_UPC;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Underflow handling: with stack checking, a pop on an empty stack is not
  // forwarded to the slices; otherwise it is driven and the SP just floors.
  // ---------------------------------------------------------------------------
`ifdef AM2909_SEQ_CTRL_STACK_CHECK_EN
  logic w_pop_empty;
  logic w_push_full;
  logic r_ovf;
  logic r_unf;

  assign w_pop_empty = w_pop & w_empty;
  assign w_push_full = w_push & w_full;
  assign w_pop_eff   = w_pop & ~w_empty;

  always_ff @(posedge CP) begin
    if (RST) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (!HOLD) begin
      if (w_push_full) r_ovf <= 1'b1;
      if (w_pop_empty) r_unf <= 1'b1;
    end
  end

  assign OVF = r_ovf;
  assign UNF = r_unf;
`else
  assign w_pop_eff = w_pop;
  assign OVF       = 1'b0;
  assign UNF       = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Output stage: RST forces JZ controls, HOLD re-issues the current address
  // by selecting uPC with carry-in cleared.
  // ---------------------------------------------------------------------------
  always_comb begin
    S      = w_s;
    FE_n   = ~(w_push | w_pop_eff);
    PUP    = w_push;
    RE_n   = w_re_n;
    ZERO_n = w_zero_n;
    C      = 1'b1;
    PL_n   = w_pl_n;
    MAP_n  = w_map_n;
    VECT_n = w_vect_n;

    if (RST) begin
      S      = SEL_UPC;
      FE_n   = 1'b1;
      PUP    = 1'b0;
      RE_n   = 1'b1;
      ZERO_n = 1'b0;
      C      = 1'b1;
      PL_n   = 1'b0;
      MAP_n  = 1'b1;
      VECT_n = 1'b1;
    end else if (HOLD) begin
      S      = SEL_UPC;
      FE_n   = 1'b1;
      RE_n   = 1'b1;
      ZERO_n = 1'b1;
      C      = 1'b0;
    end
  end

  assign CNT_ZERO = ~w_cnt_nz;
  assign FULL     = w_full;

  // ---------------------------------------------------------------------------
  // Loop counter and shadow stack pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge CP) begin
    if (RST) begin
      r_cnt <= '0;
      r_sp  <= '0;
    end else if (!HOLD) begin
      // Load and decrement are never requested together.
      if (w_load)
        r_cnt <= D;
      else if (w_dec && w_cnt_nz)
        r_cnt <= r_cnt - CW'(1);

      // SP saturates at both ends; a push at FULL overwrites the slice top.
      if (w_clr_sp)
        r_sp <= '0;
      else if (w_push && !w_full)
        r_sp <= r_sp + SPW'(1);
      else if (w_pop && !w_empty)
        r_sp <= r_sp - SPW'(1);
    end
  end

endmodule

// File: tb/tb_am2909_seq_ctrl.sv
module tb_am2909_seq_ctrl;

`ifdef AM2909_SEQ_CTRL_STACK_CHECK_EN
  localparam logic K = 1'b1;
`else
  localparam logic K = 1'b0;
`endif

  logic        CP = 1'b0;
  logic        RST = 1'b1;
  logic [3:0]  I = 4'd14;
  logic        CC_n = 1'b1;
  logic        CCEN_n = 1'b1;
  logic        HOLD = 1'b0;
  logic [11:0] D = 12'd0;
  logic [1:0]  S;
  logic        FE_n, PUP, RE_n, ZERO_n, C, PL_n, MAP_n, VECT_n;
  logic        CNT_ZERO, FULL, OVF, UNF;

  am2909_seq_ctrl #(.CW(12), .STACK_DEPTH(4)) dut (
    .CP(CP), .RST(RST), .I(I), .CC_n(CC_n), .CCEN_n(CCEN_n), .HOLD(HOLD), .D(D),
    .S(S), .FE_n(FE_n), .PUP(PUP), .RE_n(RE_n), .ZERO_n(ZERO_n), .C(C),
    .PL_n(PL_n), .MAP_n(MAP_n), .VECT_n(VECT_n),
    .CNT_ZERO(CNT_ZERO), .FULL(FULL), .OVF(OVF), .UNF(UNF)
  );

  always #5 CP = ~CP;

  // exp = {S, FE_n, PUP, RE_n, ZERO_n, C, PL_n, MAP_n, VECT_n, CNT_ZERO, FULL, OVF, UNF}
  typedef struct {
    logic        rst;
    logic [3:0]  i;
    logic        ccn;
    logic        ccen;
    logic        hold;
    logic [11:0] d;
    logic [14:0] exp;
  } vec_t;

  typedef struct {
    int          id;
    logic [14:0] exp;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic rst, input logic [3:0] i, input logic ccn, input logic ccen,
    input logic hold, input logic [11:0] d, input logic [1:0] s,
    input logic fe, input logic pup, input logic re, input logic zr,
    input logic c, input logic pl, input logic mp, input logic vc,
    input logic cz, input logic fl, input logic ov, input logic un);
    vec_t v;
    v.rst = rst; v.i = i; v.ccn = ccn; v.ccen = ccen; v.hold = hold; v.d = d;
    v.exp = {s, fe, pup, re, zr, c, pl, mp, vc, cz, fl, ov, un};
    return v;
  endfunction

  // Drive one cycle of stimulus and queue its expected outputs.
  task automatic apply(input vec_t v, input int id);
    sb_t e;
    @(posedge CP);
    #1;
    RST = v.rst; I = v.i; CC_n = v.ccn; CCEN_n = v.ccen; HOLD = v.hold; D = v.d;
    e.id = id;
    e.exp = v.exp;
    sb.push_back(e);
  endtask

  // Outputs are sampled on the falling edge, half a cycle after the drive.
  always @(negedge CP) begin
    if (sb.size() != 0) begin
      sb_t         e;
      logic [14:0] act;
      e   = sb.pop_front();
      act = {S, FE_n, PUP, RE_n, ZERO_n, C, PL_n, MAP_n, VECT_n, CNT_ZERO, FULL, OVF, UNF};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL vec%0d I=%0d got S/FE/PUP/RE/ZR/C/PL/MAP/VECT/CZ/FULL/OVF/UNF=%b want %b",
                 e.id, I, act, e.exp);
      end else begin
        $display("ok   vec%0d I=%0d outputs=%b", e.id, I, act);
      end
    end
  end

  initial begin
    // --------------------------- vector table ---------------------------
    // Reset with CJS+pass presented: JZ controls win.
    tbl.push_back(mk(1, 4'd1,  0,0,0, 12'd0, 2'b00, 1,0,1,0,1,0,1,1, 1,0,0,0));
    // LDCT 3, RPCT x4
    tbl.push_back(mk(0, 4'd12, 1,1,0, 12'd3, 2'b00, 1,0,0,1,1,0,1,1, 1,0,0,0));
    tbl.push_back(mk(0, 4'd9,  1,1,0, 12'd0, 2'b11, 1,0,1,1,1,0,1,1, 0,0,0,0));
    tbl.push_back(mk(0, 4'd9,  1,1,0, 12'd0, 2'b11, 1,0,1,1,1,0,1,1, 0,0,0,0));
    tbl.push_back(mk(0, 4'd9,  1,1,0, 12'd0, 2'b11, 1,0,1,1,1,0,1,1, 0,0,0,0));
    tbl.push_back(mk(0, 4'd9,  1,1,0, 12'd0, 2'b00, 1,0,1,1,1,0,1,1, 1,0,0,0));
    // CJS pass x5: FULL after the 4th, 5th still pushes
    tbl.push_back(mk(0, 4'd1,  1,1,0, 12'd0, 2'b11, 0,1,1,1,1,0,1,1, 1,0,0,0));
    tbl.push_back(mk(0, 4'd1,  0,0,0, 12'd0, 2'b11, 0,1,1,1,1,0,1,1, 1,0,0,0));
    tbl.push_back(mk(0, 4'd1,  0,0,0, 12'd0, 2'b11, 0,1,1,1,1,0,1,1, 1,0,0,0));
    tbl.push_back(mk(0, 4'd1,  0,0,0, 12'd0, 2'b11, 0,1,1,1,1,0,1,1, 1,0,0,0));
    tbl.push_back(mk(0, 4'd1,  0,0,0, 12'd0, 2'b11, 0,1,1,1,1,0,1,1, 1,1,0,0));
    // CJS fail, CRTN fail, then CRTN pass down to empty and one more
    tbl.push_back(mk(0, 4'd1,  1,0,0, 12'd0, 2'b00, 1,0,1,1,1,0,1,1, 1,1,K,0));
    tbl.push_back(mk(0, 4'd10, 1,0,0, 12'd0, 2'b00, 1,0,1,1,1,0,1,1, 1,1,K,0));
    tbl.push_back(mk(0, 4'd10, 0,0,0, 12'd0, 2'b10, 0,0,1,1,1,0,1,1, 1,1,K,0));
    tbl.push_back(mk(0, 4'd10, 0,0,0, 12'd0, 2'b10, 0,0,1,1,1,0,1,1, 1,0,K,0));
    tbl.push_back(mk(0, 4'd10, 0,0,0, 12'd0, 2'b10, 0,0,1,1,1,0,1,1, 1,0,K,0));
    tbl.push_back(mk(0, 4'd10, 0,0,0, 12'd0, 2'b10, 0,0,1,1,1,0,1,1, 1,0,K,0));
    tbl.push_back(mk(0, 4'd10, 0,0,0, 12'd0, 2'b10, K,0,1,1,1,0,1,1, 1,0,K,0));
    tbl.push_back(mk(0, 4'd14, 1,1,0, 12'd0, 2'b00, 1,0,1,1,1,0,1,1, 1,0,K,K));
    // LDCT 5, RFCT under HOLD x2, then RFCT counts 5..1, then exits with pop
    tbl.push_back(mk(0, 4'd12, 1,1,0, 12'd5, 2'b00, 1,0,0,1,1,0,1,1, 1,0,K,K));
    tbl.push_back(mk(0, 4'd8,  1,1,1, 12'd0, 2'b00, 1,0,1,1,0,0,1,1, 0,0,K,K));
    tbl.push_back(mk(0, 4'd8,  1,1,1, 12'd0, 2'b00, 1,0,1,1,0,0,1,1, 0,0,K,K));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 4'd8, 1,1,0, 12'd0, 2'b10, 1,0,1,1,1,0,1,1, 0,0,K,K));
    tbl.push_back(mk(0, 4'd8,  1,1,0, 12'd0, 2'b00, K,0,1,1,1,0,1,1, 1,0,K,K));
    // D-source selection
    tbl.push_back(mk(0, 4'd2,  1,1,0, 12'd0, 2'b11, 1,0,1,1,1,1,0,1, 1,0,K,K));
    tbl.push_back(mk(0, 4'd6,  1,1,0, 12'd0, 2'b11, 1,0,1,1,1,1,1,0, 1,0,K,K));
    tbl.push_back(mk(0, 4'd6,  1,0,0, 12'd0, 2'b00, 1,0,1,1,1,0,1,1, 1,0,K,K));
    // JZ, PUSH+load 2, JSRP fail, JRP pass, CJPP pass, LOOP fail/pass
    tbl.push_back(mk(0, 4'd0,  1,1,0, 12'd0, 2'b00, 1,0,1,0,1,0,1,1, 1,0,K,K));
    tbl.push_back(mk(0, 4'd4,  1,1,0, 12'd2, 2'b00, 0,1,1,1,1,0,1,1, 1,0,K,K));
    tbl.push_back(mk(0, 4'd5,  1,0,0, 12'd0, 2'b01, 0,1,1,1,1,0,1,1, 0,0,K,K));
    tbl.push_back(mk(0, 4'd7,  1,1,0, 12'd0, 2'b11, 1,0,1,1,1,0,1,1, 0,0,K,K));
    tbl.push_back(mk(0, 4'd11, 1,1,0, 12'd0, 2'b11, 0,0,1,1,1,0,1,1, 0,0,K,K));
    tbl.push_back(mk(0, 4'd13, 1,0,0, 12'd0, 2'b10, 1,0,1,1,1,0,1,1, 0,0,K,K));
    tbl.push_back(mk(0, 4'd13, 1,1,0, 12'd0, 2'b00, 0,0,1,1,1,0,1,1, 0,0,K,K));
    // TWB fail with counter 2,1,0 (last one branches to D and pops empty)
    tbl.push_back(mk(0, 4'd15, 1,0,0, 12'd0, 2'b10, 1,0,1,1,1,0,1,1, 0,0,K,K));
    tbl.push_back(mk(0, 4'd15, 1,0,0, 12'd0, 2'b10, 1,0,1,1,1,0,1,1, 0,0,K,K));
    tbl.push_back(mk(0, 4'd15, 1,0,0, 12'd0, 2'b11, K,0,1,1,1,0,1,1, 1,0,K,K));
    // CJP pass/fail
    tbl.push_back(mk(0, 4'd3,  1,1,0, 12'd0, 2'b11, 1,0,1,1,1,0,1,1, 1,0,K,K));
    tbl.push_back(mk(0, 4'd3,  1,0,0, 12'd0, 2'b00, 1,0,1,1,1,0,1,1, 1,0,K,K));
    // Reset overrides HOLD and PUSH-with-load; flags clear on the edge
    tbl.push_back(mk(1, 4'd4,  1,1,1, 12'd7, 2'b00, 1,0,1,0,1,0,1,1, 1,0,K,K));
    tbl.push_back(mk(0, 4'd14, 1,1,0, 12'd0, 2'b00, 1,0,1,1,1,0,1,1, 1,0,0,0));
    // PUSH on fail must not load the counter
    tbl.push_back(mk(0, 4'd4,  1,0,0, 12'd7, 2'b00, 0,1,1,1,1,0,1,1, 1,0,0,0));
    tbl.push_back(mk(0, 4'd14, 1,1,0, 12'd0, 2'b00, 1,0,1,1,1,0,1,1, 1,0,0,0));

    // Settle into a known state before the checked run.
    repeat (2) @(posedge CP);

    for (int n = 0; n < tbl.size(); n++)
      apply(tbl[n], n);

    // ------------- hand sequence: HOLD freezes a full stack -------------
    apply(mk(1, 4'd14, 1,1,0, 12'd0, 2'b00, 1,0,1,0,1,0,1,1, 1,0,0,0), 100);
    for (int k = 0; k < 4; k++)
      apply(mk(0, 4'd1, 1,1,0, 12'd0, 2'b11, 0,1,1,1,1,0,1,1, 1,0,0,0), 101 + k);
    apply(mk(0, 4'd10, 0,0,1, 12'd0, 2'b00, 1,0,1,1,0,0,1,1, 1,1,0,0), 105);
    apply(mk(0, 4'd14, 1,1,0, 12'd0, 2'b00, 1,0,1,1,1,0,1,1, 1,1,0,0), 106);
    apply(mk(0, 4'd10, 0,0,0, 12'd0, 2'b10, 0,0,1,1,1,0,1,1, 1,1,0,0), 107);
    apply(mk(0, 4'd14, 1,1,0, 12'd0, 2'b00, 1,0,1,1,1,0,1,1, 1,0,0,0), 108);

    // ------------ hand sequence: counter load of an all-ones value ------------
    apply(mk(0, 4'd12, 1,1,0, 12'hFFF, 2'b00, 1,0,0,1,1,0,1,1, 1,0,0,0), 110);
    apply(mk(0, 4'd9,  1,1,0, 12'd0,   2'b11, 1,0,1,1,1,0,1,1, 0,0,0,0), 111);
    apply(mk(0, 4'd0,  1,1,0, 12'd0,   2'b00, 1,0,1,0,1,0,1,1, 0,0,0,0), 112);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 5 && sb.size() != 0; k++)
      @(posedge CP);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
